// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and constants for the write-back arbiter slice.
//   NUM_REGS   : architectural register count (register 0 is hardwired zero)
//   REG_AW     : register address width
//   DATA_W     : result data width
//   wb_entry_t : one buffered write-back result (destination + value)
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage : wb_arbiter_pkg

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular result buffer with occupancy count.
// Parameters:
//   DEPTH   : number of entries (power of two, >= 2)
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write one entry (caller guarantees count < DEPTH)
//   pop          : drop the head entry (caller guarantees count > 0)
//   head         : current head entry (valid when !empty)
//   count        : occupancy, 0..DEPTH
//   empty        : count == 0
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  wb_entry_t                din,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is data only; a reset merely invalidates it through the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule : wb_fifo

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Register-file write-back arbiter. The ALU path has priority and no
// backpressure; LSU results queue in wb_fifo and drain when the ALU is idle.
// A starvation counter forces a one-cycle alu_stall so the FIFO head drains.
// Optional pending-write scoreboard, enabled by defining WB_SCOREBOARD_EN.
// Parameters:
//   FIFO_DEPTH   : LSU result buffer entries (power of two, >= 2)
//   STARVE_LIMIT : cycles the FIFO head may lose before alu_stall is forced
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     : ALU result (no backpressure)
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result handshake
//   alu_stall                     : registered; upstream must hold alu_valid low
//   RegWrite/w_reg_addr/w_data    : registered register-file write port
//   fifo_count                    : buffer occupancy
//   alloc_valid/alloc_rd          : issue-side pending-destination allocation
//   chk_rs1/chk_rs2, busy1/busy2  : pending-write query
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          alu_valid,
    input  logic [4:0]                    alu_rd,
    input  logic [31:0]                   alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [4:0]                    lsu_rd,
    input  logic [31:0]                   lsu_data,
    output logic                          alu_stall,
    output logic                          RegWrite,
    output logic [4:0]                    w_reg_addr,
    output logic [31:0]                   w_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          alloc_valid,
    input  logic [4:0]                    alloc_rd,
    input  logic [4:0]                    chk_rs1,
    input  logic [4:0]                    chk_rs2,
    output logic                          busy1,
    output logic                          busy2
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t     fifo_head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          sel_alu;
    logic          sel_vld_p0;
    wb_entry_t     sel_entry_p0;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    // Ready comes from the registered count, so a pop in the same cycle
    // cannot make room for a push. Destination-0 results are accepted but
    // never stored.
    assign lsu_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     ('{rd: lsu_rd, data: lsu_data}),
        .pop     (pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    // ---- stage p0: source selection ----
    // While alu_stall is high any alu_valid is a protocol error and is ignored,
    // which hands the cycle to the FIFO head.
    always_comb begin
        sel_alu      = 1'b0;
        pop          = 1'b0;
        sel_vld_p0   = 1'b0;
        sel_entry_p0 = '0;
        if (alu_valid && !alu_stall) begin
            sel_alu      = 1'b1;
            sel_vld_p0   = 1'b1;
            sel_entry_p0 = '{rd: alu_rd, data: alu_data};
        end else if (!fifo_empty) begin
            pop          = 1'b1;
            sel_vld_p0   = 1'b1;
            sel_entry_p0 = fifo_head;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (sel_alu) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    // ---- stage p1: registered write port and stall ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
            RegWrite   <= 1'b0;
            w_reg_addr <= '0;
            w_data     <= '0;
        end else begin
            starve_cnt <= starve_next;
            alu_stall  <= (starve_next == SW'(STARVE_LIMIT));
            RegWrite   <= sel_vld_p0 && (sel_entry_p0.rd != '0);
            if (sel_vld_p0) begin
                w_reg_addr <= sel_entry_p0.rd;
                w_data     <= sel_entry_p0.data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;

    // Clear for the write being issued, then set for a new allocation, so an
    // allocation in the same cycle as a write to that register keeps it busy.
    always_comb begin
        pending_next = pending;
        if (RegWrite) begin
            pending_next[w_reg_addr] = 1'b0;
        end
        if (alloc_valid && (alloc_rd != '0)) begin
            pending_next[alloc_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign busy1 = (chk_rs1 != '0) && pending[chk_rs1];
    assign busy2 = (chk_rs2 != '0) && pending[chk_rs2];
`else
    logic unused_sb;
    assign unused_sb = ^{alloc_valid, alloc_rd, chk_rs1, chk_rs2};
    assign busy1     = 1'b0;
    assign busy2     = 1'b0;
`endif

    a_no_alu_during_stall : assert property (
        @(posedge clk) disable iff (!reset_n) !(alu_stall && alu_valid)
    ) else $error("wb_arbiter: alu_valid asserted while alu_stall, result dropped");

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed self-checking bench for wb_arbiter (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Scoreboard checks follow WB_SCOREBOARD_EN.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        alu_valid, lsu_valid, alloc_valid;
    logic [4:0]  alu_rd, lsu_rd, alloc_rd, chk_rs1, chk_rs2;
    logic [31:0] alu_data, lsu_data;
    logic        lsu_ready, alu_stall, RegWrite, busy1, busy2;
    logic [4:0]  w_reg_addr;
    logic [31:0] w_data;
    logic [2:0]  fifo_count;

    int total  = 0;
    int passed = 0;

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .alu_stall(alu_stall), .RegWrite(RegWrite), .w_reg_addr(w_reg_addr), .w_data(w_data),
        .fifo_count(fifo_count),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        alloc_valid = 0; alloc_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #2 reset_n = 0;
        #1;
        total++; if (RegWrite !== 1'b0) $display("FAIL reset_regwrite got=%0b want=0", RegWrite); else passed++;
        step(); step();
        total++; if (w_reg_addr !== 5'd0) $display("FAIL reset_addr got=%0d want=0", w_reg_addr); else passed++;
        total++; if (w_data !== 32'd0) $display("FAIL reset_data got=%0h want=0", w_data); else passed++;
        total++; if (alu_stall !== 1'b0) $display("FAIL reset_stall got=%0b want=0", alu_stall); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d want=0", fifo_count); else passed++;
        total++; if (lsu_ready !== 1'b1) $display("FAIL reset_ready got=%0b want=1", lsu_ready); else passed++;
        reset_n = 1;
        step();
        total++; if (RegWrite !== 1'b0) $display("FAIL post_reset_regwrite got=%0b want=0", RegWrite); else passed++;
    endtask

    task automatic test_alu_only();
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        step();
        idle();
        total++; if (RegWrite !== 1'b1) $display("FAIL alu_regwrite got=%0b want=1", RegWrite); else passed++;
        total++; if (w_reg_addr !== 5'd5) $display("FAIL alu_addr got=%0d want=5", w_reg_addr); else passed++;
        total++; if (w_data !== 32'h1234) $display("FAIL alu_data got=%0h want=1234", w_data); else passed++;
        step();
        total++; if (RegWrite !== 1'b0) $display("FAIL alu_idle_regwrite got=%0b want=0", RegWrite); else passed++;
    endtask

    task automatic test_contention();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hAA;
        total++; if (lsu_ready !== 1'b1) $display("FAIL cont_ready got=%0b want=1", lsu_ready); else passed++;
        step();
        idle();
        total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'd3) $display("FAIL cont_first got=%0b/%0d want=1/3", RegWrite, w_reg_addr); else passed++;
        total++; if (fifo_count !== 3'd1) $display("FAIL cont_count got=%0d want=1", fifo_count); else passed++;
        step();
        total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'd7) $display("FAIL cont_second got=%0b/%0d want=1/7", RegWrite, w_reg_addr); else passed++;
        total++; if (w_data !== 32'hAA) $display("FAIL cont_second_data got=%0h want=aa", w_data); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL cont_drained got=%0d want=0", fifo_count); else passed++;
        step();
        total++; if (RegWrite !== 1'b0) $display("FAIL cont_idle got=%0b want=0", RegWrite); else passed++;
    endtask

    task automatic test_full();
        alu_valid = 1; alu_rd = 2;
        for (int i = 0; i < 4; i++) begin
            alu_data = 32'h100 + i;
            lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'hA0 + i;
            step();
        end
        total++; if (w_reg_addr !== 5'd2 || w_data !== 32'h103) $display("FAIL full_alu_wins got=%0d/%0h want=2/103", w_reg_addr, w_data); else passed++;
        total++; if (fifo_count !== 3'd4) $display("FAIL full_count got=%0d want=4", fifo_count); else passed++;
        total++; if (lsu_ready !== 1'b0) $display("FAIL full_ready got=%0b want=0", lsu_ready); else passed++;
        lsu_rd = 14; lsu_data = 32'hEE;
        step();
        total++; if (fifo_count !== 3'd4) $display("FAIL full_reject got=%0d want=4", fifo_count); else passed++;
        // Pop while full: ready stays low this cycle, so rd=15 is not taken.
        alu_valid = 0; lsu_rd = 15; lsu_data = 32'hFF;
        step();
        lsu_valid = 0;
        total++; if (fifo_count !== 3'd3) $display("FAIL full_pop_noready got=%0d want=3", fifo_count); else passed++;
        total++; if (lsu_ready !== 1'b1) $display("FAIL full_ready_after_pop got=%0b want=1", lsu_ready); else passed++;
        total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'd10 || w_data !== 32'hA0) $display("FAIL drain0 got=%0b/%0d/%0h want=1/10/a0", RegWrite, w_reg_addr, w_data); else passed++;
        for (int i = 1; i < 4; i++) begin
            step();
            total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'(10 + i) || w_data !== 32'hA0 + i) $display("FAIL drain%0d got=%0b/%0d/%0h want=1/%0d/%0h", i, RegWrite, w_reg_addr, w_data, 10 + i, 32'hA0 + i); else passed++;
        end
        step();
        total++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) $display("FAIL drain_done got=%0b/%0d want=0/0", RegWrite, fifo_count); else passed++;
    endtask

    task automatic test_starvation();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h40;
        lsu_valid = 1; lsu_rd = 20; lsu_data = 32'hBEEF;
        step();
        lsu_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            alu_data = 32'h40 + i;
            step();
            total++; if (alu_stall !== (i == 8)) $display("FAIL starve_stall_c%0d got=%0b want=%0b", i, alu_stall, (i == 8)); else passed++;
        end
        total++; if (w_reg_addr !== 5'd4 || w_data !== 32'h48) $display("FAIL starve_alu got=%0d/%0h want=4/48", w_reg_addr, w_data); else passed++;
        alu_valid = 0;
        step();
        total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'd20 || w_data !== 32'hBEEF) $display("FAIL starve_head got=%0b/%0d/%0h want=1/20/beef", RegWrite, w_reg_addr, w_data); else passed++;
        total++; if (alu_stall !== 1'b0) $display("FAIL starve_one_cycle got=%0b want=0", alu_stall); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL starve_count got=%0d want=0", fifo_count); else passed++;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h60;
        step(); step();
        idle();
        total++; if (alu_stall !== 1'b0) $display("FAIL starve_empty_nostall got=%0b want=0", alu_stall); else passed++;
    endtask

    task automatic test_rd_zero();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
        total++; if (lsu_ready !== 1'b1) $display("FAIL rd0_ready got=%0b want=1", lsu_ready); else passed++;
        step();
        idle();
        total++; if (fifo_count !== 3'd0) $display("FAIL rd0_count got=%0d want=0", fifo_count); else passed++;
        step();
        total++; if (RegWrite !== 1'b0) $display("FAIL rd0_lsu_regwrite got=%0b want=0", RegWrite); else passed++;
        alu_valid = 1; alu_rd = 0; alu_data = 32'h77;
        step();
        idle();
        total++; if (RegWrite !== 1'b0) $display("FAIL rd0_alu_regwrite got=%0b want=0", RegWrite); else passed++;
    endtask

    task automatic test_reset_mid();
        alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
        lsu_valid = 1; lsu_rd = 21; lsu_data = 32'h2121;
        step();
        lsu_rd = 22; lsu_data = 32'h2222;
        step();
        total++; if (fifo_count !== 3'd2) $display("FAIL mid_count_before got=%0d want=2", fifo_count); else passed++;
        reset_n = 0;
        #1;
        total++; if (fifo_count !== 3'd0 || RegWrite !== 1'b0) $display("FAIL mid_async_clear got=%0d/%0b want=0/0", fifo_count, RegWrite); else passed++;
        idle();
        step();
        reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (RegWrite !== 1'b0) $display("FAIL mid_no_write%0d got=%0b want=0", i, RegWrite); else passed++;
        end
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1; alloc_rd = 9; chk_rs1 = 9; chk_rs2 = 0;
        step();
        alloc_valid = 0;
`ifdef WB_SCOREBOARD_EN
        total++; if (busy1 !== 1'b1) $display("FAIL sb_set got=%0b want=1", busy1); else passed++;
        total++; if (busy2 !== 1'b0) $display("FAIL sb_r0 got=%0b want=0", busy2); else passed++;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        step();
        alu_valid = 0;
        total++; if (busy1 !== 1'b1) $display("FAIL sb_still_busy got=%0b want=1", busy1); else passed++;
        step();
        total++; if (busy1 !== 1'b0) $display("FAIL sb_cleared got=%0b want=0", busy1); else passed++;
        alloc_valid = 1; alloc_rd = 9;
        step();
        alloc_valid = 0; alu_valid = 1; alu_rd = 9;
        step();
        alu_valid = 0; alloc_valid = 1; alloc_rd = 9;
        total++; if (RegWrite !== 1'b1 || w_reg_addr !== 5'd9) $display("FAIL sb_write9 got=%0b/%0d want=1/9", RegWrite, w_reg_addr); else passed++;
        step();
        alloc_valid = 0;
        total++; if (busy1 !== 1'b1) $display("FAIL sb_set_wins got=%0b want=1", busy1); else passed++;
        step();
        total++; if (busy1 !== 1'b1) $display("FAIL sb_set_holds got=%0b want=1", busy1); else passed++;
`else
        total++; if (busy1 !== 1'b0 || busy2 !== 1'b0) $display("FAIL sb_disabled got=%0b/%0b want=0/0", busy1, busy2); else passed++;
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_contention();
        test_full();
        test_starvation();
        test_rd_zero();
        test_reset_mid();
        test_scoreboard();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, LSU result buffer entries; power of two, minimum 2.
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive cycles a non-empty FIFO head may lose arbitration before the stall is forced.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid  input  1  single-cycle-path result present; no backpressure.
REQ-006 alu_rd  input  5  ALU result destination register.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 lsu_valid  input  1  load/multi-cycle result offered.
REQ-009 lsu_ready  output  1  buffer can accept; transfer occurs when lsu_valid and lsu_ready are both 1.
REQ-010 lsu_rd  input  5  LSU result destination register.
REQ-011 lsu_data  input  32  LSU result value.
REQ-012 alu_stall  output  1  registered; upstream SHALL hold alu_valid low while it is 1.
REQ-013 RegWrite  output  1  register-file write enable, registered.
REQ-014 w_reg_addr  output  5  register-file write address, registered.
REQ-015 w_data  output  32  register-file write data, registered.
REQ-016 fifo_count  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-017 alloc_valid, alloc_rd  input  1, 5  issue-side pending-destination allocation.
REQ-018 chk_rs1, chk_rs2  input  5 each; busy1, busy2  output  1 each: pending-write query.

Function
REQ-019 Each cycle exactly one source is selected: the ALU when alu_valid=1, otherwise the FIFO head when the FIFO is non-empty, otherwise none.
REQ-020 Selected result appears on RegWrite/w_reg_addr/w_data one cycle after selection; RegWrite=0 in cycles following no selection.
REQ-021 Any result with destination 0 produces RegWrite=0; an LSU result with lsu_rd=0 is accepted and discarded, never enqueued.
REQ-022 lsu_ready = (fifo_count < FIFO_DEPTH), computed from registered count only; a same-cycle pop does not raise lsu_ready.
REQ-023 Simultaneous push and pop leave fifo_count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-024 FIFO order is strict first-in first-out; no reordering.
REQ-025 Starvation counter increments each cycle the FIFO is non-empty and the ALU wins; clears on any FIFO pop or when the FIFO is empty.
REQ-026 When the counter reaches STARVE_LIMIT, alu_stall=1 the next cycle for exactly one cycle; in that cycle the FIFO head is selected regardless of alu_valid.
REQ-027 alu_valid=1 while alu_stall=1 is a protocol error; the ALU result is dropped and a simulation assertion fires.

Reset
REQ-028 reset_n=0 immediately clears RegWrite, w_reg_addr, w_data, alu_stall, pointers, fifo_count, starvation counter and the pending bitmap; lsu_ready=1 after reset.
REQ-029 Reset mid-operation discards all buffered results; no write is issued for them.

Configuration
REQ-030 With WB_SCOREBOARD_EN defined: a 32-bit pending bitmap; alloc_valid with alloc_rd!=0 sets the bit; an issued write (RegWrite=1) clears bit w_reg_addr; same-cycle set and clear of one bit -> set wins; busy1/busy2 = pending[chk_rs1]/pending[chk_rs2], register 0 always 0.
REQ-031 Without WB_SCOREBOARD_EN: no bitmap; alloc ports ignored; busy1=busy2=0.

Structure
REQ-032 Shared package holds the wb_entry_t typedef (5-bit rd, 32-bit data) and the register-count/address-width constants.
REQ-033 One sub-module, wb_fifo (parameterised buffer with count), is instantiated; arbitration, starvation logic and scoreboard stay in wb_arbiter.

Verification
REQ-034 ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 -> next cycle RegWrite=1, w_reg_addr=5, w_data=0x1234.
REQ-035 Contention: ALU (rd=3) and LSU (rd=7, 0xAA) same cycle -> rd=3 written first, rd=7 written the first cycle with alu_valid=0.
REQ-036 Full buffer: 4 LSU pushes with alu_valid held 1 -> fifo_count=4, lsu_ready=0; further lsu_valid not accepted; drain order matches push order.
REQ-037 Starvation: FIFO non-empty, alu_valid=1 continuously for 8 cycles -> alu_stall=1 cycle 9, FIFO head written, counter cleared.
REQ-038 rd=0: LSU rd=0 push -> lsu_ready handshake completes, fifo_count unchanged, no RegWrite.
REQ-039 Scoreboard (WB_SCOREBOARD_EN): alloc rd=9 -> busy1=1 for chk_rs1=9 until write to 9 issues; alloc and write of 9 same cycle -> remains busy.
